// File: rtl/bbc_slow_access_seq.sv
// Sequences one 65816 BBC-bus access on hsclk: stalls the CPU via RDY, aligns the
// access to one complete BBC PHI2 phase, captures read data, then releases the CPU.
module bbc_slow_access_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_DLY  = 5,
  parameter int TIMEOUT_W   = 10,
  parameter int TIMEOUT     = 1023
) (
  input  logic       hsclk,
  input  logic       resetb,
  input  logic       bbc_ck2_phi0,
  input  logic       req,
  input  logic       req_rnw,
  input  logic [7:0] req_wdata,
  input  logic [7:0] bbc_data_in,
  output logic       rdy_out,
  output logic       bbc_cycle_en,
  output logic       bbc_wr_en,
  output logic [7:0] bbc_wdata,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LO,
    ST_WAIT_RISE,
    ST_PHI2,
    ST_DONE
  } state_t;

  localparam logic [3:0]           SAMPLE_CNT = 4'(SAMPLE_DLY - 1);
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST  = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] WDOG_ONE   = TIMEOUT_W'(1);

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_phi0_d;
  logic                   r_rnw;
  logic                   r_captured;
  logic [3:0]             r_cnt;
  logic [TIMEOUT_W-1:0]   r_wdog;
  logic                   r_cycle_en;
  logic                   r_wr_en;
  logic [7:0]             r_wdata;
  logic [7:0]             r_rdata;
  logic                   r_rdata_valid;
  logic                   r_timeout_err;

  logic w_phi0_s;
  logic w_rise;
  logic w_fall;
  logic w_wdog_exp;
  logic w_sample_pt;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign w_phi0_s    = r_sync[SYNC_STAGES-1];
  assign w_rise      = w_phi0_s & ~r_phi0_d;
  assign w_fall      = ~w_phi0_s & r_phi0_d;
  assign w_wdog_exp  = (r_wdog == WDOG_LAST);
  assign w_sample_pt = r_rnw & ~r_captured & (r_cnt == SAMPLE_CNT);

  // RDY falls in the request cycle itself and is forced high while in reset.
  assign rdy_out = ~resetb | (r_state == ST_DONE) | ((r_state == ST_IDLE) & ~req);

  assign bbc_cycle_en = r_cycle_en;
  assign bbc_wr_en    = r_wr_en;
  assign bbc_wdata    = r_wdata;
  assign rdata        = r_rdata;
  assign rdata_valid  = r_rdata_valid;
  assign timeout_err  = r_timeout_err;

  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      r_sync        <= '0;
      r_phi0_d      <= 1'b0;
      r_state       <= ST_IDLE;
      r_rnw         <= 1'b0;
      r_captured    <= 1'b0;
      r_cnt         <= '0;
      r_wdog        <= '0;
      r_cycle_en    <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_sync        <= {r_sync[SYNC_STAGES-2:0], bbc_ck2_phi0};
      r_phi0_d      <= w_phi0_s;
      r_rdata_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_rnw         <= req_rnw;
            r_wdata       <= req_wdata;
            r_timeout_err <= 1'b0;
            r_wdog        <= '0;
            r_captured    <= 1'b0;
            // Never join a PHI2 phase that is already under way.
            r_state       <= w_phi0_s ? ST_WAIT_LO : ST_WAIT_RISE;
          end
        end

        ST_WAIT_LO: begin
          if (!w_phi0_s) begin
            r_state <= ST_WAIT_RISE;
            r_wdog  <= '0;
          end else if (w_wdog_exp) begin
            r_state       <= ST_DONE;
            r_timeout_err <= 1'b1;
            r_rdata_valid <= 1'b1;
            r_wdog        <= '0;
          end else begin
            r_wdog <= r_wdog + WDOG_ONE;
          end
        end

        ST_WAIT_RISE: begin
          if (w_rise) begin
            r_state    <= ST_PHI2;
            r_cnt      <= '0;
            r_cycle_en <= 1'b1;
            r_wr_en    <= ~r_rnw;
            r_wdog     <= '0;
          end else if (w_wdog_exp) begin
            r_state       <= ST_DONE;
            r_timeout_err <= 1'b1;
            r_rdata_valid <= 1'b1;
            r_wdog        <= '0;
          end else begin
            r_wdog <= r_wdog + WDOG_ONE;
          end
        end

        ST_PHI2: begin
          if (w_fall) begin
            r_state       <= ST_DONE;
            r_cycle_en    <= 1'b0;
            r_wr_en       <= 1'b0;
            r_rdata_valid <= 1'b1;
            r_wdog        <= '0;
            // Late-phase fallback when the sample point lies beyond this phase.
            if (r_rnw && !r_captured) begin
              r_rdata    <= bbc_data_in;
              r_captured <= 1'b1;
            end
          end else if (w_wdog_exp) begin
            r_state       <= ST_DONE;
            r_cycle_en    <= 1'b0;
            r_wr_en       <= 1'b0;
            r_timeout_err <= 1'b1;
            r_rdata_valid <= 1'b1;
            r_wdog        <= '0;
          end else begin
            r_wdog <= r_wdog + WDOG_ONE;
            r_cnt  <= sat_inc4(r_cnt);
            if (w_sample_pt) begin
              r_rdata    <= bbc_data_in;
              r_captured <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_wdog  <= '0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bbc_slow_access_seq.sv
// Randomized bench for bbc_slow_access_seq: two instances (early and late sample
// point) share stimulus and are compared each cycle against an edge-level model.
`timescale 1ns/1ps
module tb_bbc_slow_access_seq;

  localparam int S    = 2;
  localparam int T    = 20;
  localparam int NMAX = 600;

  logic       hsclk = 1'b0;
  logic       resetb = 1'b0;
  logic       phi0 = 1'b0;
  logic       req = 1'b0;
  logic       req_rnw = 1'b0;
  logic [7:0] req_wdata = 8'h00;
  logic [7:0] din = 8'h00;

  logic       a_rdy, a_en, a_wr, a_val, a_terr;
  logic [7:0] a_wd, a_rd;
  logic       b_rdy, b_en, b_wr, b_val, b_terr;
  logic [7:0] b_wd, b_rd;

  always #5 hsclk = ~hsclk;

  bbc_slow_access_seq #(.SYNC_STAGES(S), .SAMPLE_DLY(5), .TIMEOUT_W(10), .TIMEOUT(T)) u_dut_a (
    .hsclk(hsclk), .resetb(resetb), .bbc_ck2_phi0(phi0), .req(req), .req_rnw(req_rnw),
    .req_wdata(req_wdata), .bbc_data_in(din), .rdy_out(a_rdy), .bbc_cycle_en(a_en),
    .bbc_wr_en(a_wr), .bbc_wdata(a_wd), .rdata(a_rd), .rdata_valid(a_val), .timeout_err(a_terr)
  );

  bbc_slow_access_seq #(.SYNC_STAGES(S), .SAMPLE_DLY(15), .TIMEOUT_W(10), .TIMEOUT(T)) u_dut_b (
    .hsclk(hsclk), .resetb(resetb), .bbc_ck2_phi0(phi0), .req(req), .req_rnw(req_rnw),
    .req_wdata(req_wdata), .bbc_data_in(din), .rdy_out(b_rdy), .bbc_cycle_en(b_en),
    .bbc_wr_en(b_wr), .bbc_wdata(b_wd), .rdata(b_rd), .rdata_valid(b_val), .timeout_err(b_terr)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus per active edge k, and expected values: e_rdy[k] is RDY just before
  // edge k, every other e_* array is the registered output just after edge k.
  bit         s_phi [NMAX];
  bit         s_req [NMAX];
  bit         s_rnw [NMAX];
  logic [7:0] s_wd  [NMAX];
  logic [7:0] s_din [NMAX];
  bit         e_rdy [NMAX];
  bit         e_en  [NMAX];
  bit         e_wr  [NMAX];
  bit         e_val [NMAX];
  bit         e_terr[NMAX];
  logic [7:0] e_wd  [NMAX];
  logic [7:0] e_rd_a[NMAX];
  logic [7:0] e_rd_b[NMAX];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Synchronised phi0 as seen by the sequencer at edge k.
  function automatic bit ps(input int k);
    return (k < S) ? 1'b0 : s_phi[k-S];
  endfunction

  task automatic gen(input int phi_mode, input int req_mode, input int rnw_mode,
                     input bit din_fix, input logic [7:0] din_val);
    int k;
    int len;
    bit lvl;
    lvl = 1'($urandom_range(0, 1));
    k = 0;
    while (k < NMAX) begin
      if (phi_mode == 2) len = NMAX;
      else if (phi_mode == 1) len = (k == 0) ? int'($urandom_range(1, 8)) : 8;
      else len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(22, 30))
                                             : int'($urandom_range(2, 12));
      for (int j = 0; j < len && k < NMAX; j++) begin
        s_phi[k] = lvl;
        k++;
      end
      lvl = ~lvl;
    end
    for (int m = 0; m < NMAX; m++) begin
      s_req[m] = (req_mode == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
      s_rnw[m] = (rnw_mode == 1) ? 1'b1 : (rnw_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      s_wd[m]  = 8'($urandom);
      s_din[m] = din_fix ? din_val : 8'($urandom);
    end
  endtask

  // Walks accesses one by one: find the first full PHI2 phase after acceptance,
  // with each wait limited to T cycles.
  task automatic build_expect(input int L);
    int k, k0, k1, kend, s, e, kc_a, kc_b;
    bit rnw, to, have1, terr;
    logic [7:0] rda, rdb, wd;
    rda = 8'h00; rdb = 8'h00; wd = 8'h00; terr = 1'b0; k1 = 0;
    for (int m = 0; m < NMAX; m++) begin
      e_rdy[m] = 1'b1; e_en[m] = 1'b0; e_wr[m] = 1'b0; e_val[m] = 1'b0;
      e_terr[m] = 1'b0; e_wd[m] = 8'h00; e_rd_a[m] = 8'h00; e_rd_b[m] = 8'h00;
    end
    k = 0;
    while (k < L) begin
      if (!s_req[k]) begin
        e_rdy[k] = 1'b1; e_rd_a[k] = rda; e_rd_b[k] = rdb; e_terr[k] = terr; e_wd[k] = wd;
        k++;
        continue;
      end
      k0 = k; rnw = s_rnw[k0]; wd = s_wd[k0]; terr = 1'b0;
      to = 1'b0; have1 = 1'b0; kend = 0; s = k0;
      if (ps(k0)) begin
        e = s + 1;
        while (e <= s + T && ps(e)) e++;
        if (e > s + T) begin to = 1'b1; kend = s + T; end
        else s = e;
      end
      if (!to) begin
        e = s + 1;
        while (e <= s + T && !(ps(e) && !ps(e - 1))) e++;
        if (e > s + T) begin to = 1'b1; kend = s + T; end
        else begin k1 = e; have1 = 1'b1; end
      end
      if (have1) begin
        e = k1 + 1;
        while (e <= k1 + T && ps(e)) e++;
        if (e > k1 + T) begin to = 1'b1; kend = k1 + T; end
        else kend = e;
      end
      kc_a = -1; kc_b = -1;
      if (have1 && rnw) begin
        if (k1 + 5 < kend) kc_a = k1 + 5; else if (!to) kc_a = kend;
        if (k1 + 15 < kend) kc_b = k1 + 15; else if (!to) kc_b = kend;
      end
      for (int m = k0; m <= kend; m++) begin
        e_rdy[m] = 1'b0;
        e_en[m]  = have1 && (m >= k1) && (m < kend);
        e_wr[m]  = e_en[m] && !rnw;
        e_val[m] = (m == kend);
        if (m == kc_a) rda = s_din[m];
        if (m == kc_b) rdb = s_din[m];
        if (m == kend) terr = to;
        e_rd_a[m] = rda; e_rd_b[m] = rdb; e_terr[m] = terr; e_wd[m] = wd;
      end
      // The cycle spent in DONE: a held request is not accepted until the next one.
      e_rdy[kend+1] = 1'b1; e_rd_a[kend+1] = rda; e_rd_b[kend+1] = rdb;
      e_terr[kend+1] = terr; e_wd[kend+1] = wd;
      k = kend + 2;
    end
  endtask

  task automatic check_cycle(input int k);
    bit en, wr, val, terr;
    logic [7:0] wd, rda, rdb;
    if (k == 0) begin
      en = 0; wr = 0; val = 0; terr = 0; wd = 8'h00; rda = 8'h00; rdb = 8'h00;
    end else begin
      en = e_en[k-1]; wr = e_wr[k-1]; val = e_val[k-1]; terr = e_terr[k-1];
      wd = e_wd[k-1]; rda = e_rd_a[k-1]; rdb = e_rd_b[k-1];
    end
    check_eq($sformatf("rdy_a@%0d", k), a_rdy, e_rdy[k]);
    check_eq($sformatf("rdy_b@%0d", k), b_rdy, e_rdy[k]);
    check_eq($sformatf("cycle_en_a@%0d", k), a_en, en);
    check_eq($sformatf("cycle_en_b@%0d", k), b_en, en);
    check_eq($sformatf("wr_en_a@%0d", k), a_wr, wr);
    check_eq($sformatf("wr_en_b@%0d", k), b_wr, wr);
    check_eq($sformatf("valid_a@%0d", k), a_val, val);
    check_eq($sformatf("valid_b@%0d", k), b_val, val);
    check_eq($sformatf("timeout_a@%0d", k), a_terr, terr);
    check_eq($sformatf("timeout_b@%0d", k), b_terr, terr);
    check_eq($sformatf("wdata_a@%0d", k), a_wd, wd);
    check_eq($sformatf("wdata_b@%0d", k), b_wd, wd);
    check_eq($sformatf("rdata_a@%0d", k), a_rd, rda);
    check_eq($sformatf("rdata_b@%0d", k), b_rd, rdb);
  endtask

  task automatic run_trace(input int L, input int abort_k);
    resetb = 1'b0;
    req = 1'b0;
    repeat (3) @(negedge hsclk);
    resetb = 1'b1;
    for (int k = 0; k < L; k++) begin
      if (k > 0) @(negedge hsclk);
      phi0 = s_phi[k]; req = s_req[k]; req_rnw = s_rnw[k];
      req_wdata = s_wd[k]; din = s_din[k];
      if (k == abort_k) begin
        req = 1'b1;
        #1 resetb = 1'b0;
        #1;
        check_eq("abort_cycle_en_a", a_en, 0);
        check_eq("abort_cycle_en_b", b_en, 0);
        check_eq("abort_wr_en_a", a_wr, 0);
        check_eq("abort_wr_en_b", b_wr, 0);
        check_eq("abort_rdy_a", a_rdy, 1);
        check_eq("abort_rdy_b", b_rdy, 1);
        break;
      end
      #3;
      check_cycle(k);
    end
  endtask

  initial begin
    int ab;
    // Back-to-back reads on a regular 8/8 clock with constant read data.
    gen(1, 1, 1, 1'b1, 8'hA5);
    build_expect(200);
    run_trace(200, -1);
    // Sparse writes on a regular clock.
    gen(1, 0, 2, 1'b0, 8'h00);
    build_expect(200);
    run_trace(200, -1);
    // Irregular phases including over-long ones that trip the watchdog.
    for (int r = 0; r < 4; r++) begin
      gen(0, 0, 0, 1'b0, 8'h00);
      build_expect(400);
      run_trace(400, -1);
    end
    // phi0 frozen: every access must end by timeout.
    gen(2, 0, 0, 1'b0, 8'h00);
    build_expect(200);
    run_trace(200, -1);
    // Reset in the middle of a write's PHI2 phase, then normal reads afterwards.
    gen(1, 1, 2, 1'b0, 8'h00);
    build_expect(200);
    ab = -1;
    for (int m = 0; m < 150; m++) begin
      if (ab < 0 && e_wr[m]) ab = m + 3;
    end
    run_trace(200, ab);
    gen(1, 0, 1, 1'b0, 8'h00);
    build_expect(200);
    run_trace(200, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
